bcd_to_bin_seq: RTL and testbench
=================================

// Module: bcd_to_bin_seq
// PURPOSE
//   Sequential packed-BCD to binary converter (reverse double-dabble), the inverse of the binary-to-BCD path
//   feeding the seven-segment displays. Converts operator-entered decimal digits back to binary for the
//   arithmetic datapath. Start/busy/done handshake, one shift step per clock, flags overflow and bad digits.
// PARAMETERS
//   NDIGITS  5   number of BCD digits on input (digit 0 = least significant nibble)
//   WIDTH    16  binary result width; also number of shift iterations
//   CNTW     derived localparam = $clog2(WIDTH+1), iteration counter width (5 at defaults)
// PORTS
//   clk    in   1           system clock, all state on rising edge
//   reset  in   1           asynchronous, active-low reset
//   start  in   1           request conversion; sampled only when busy=0
//   bcd    in   4*NDIGITS   packed BCD operand, bcd[3:0] = units digit; sampled on accepted start
//   bin    out  WIDTH       result = decimal value mod 2^WIDTH; held until next accepted start
//   busy   out  1           high while conversion in progress
//   done   out  1           one-cycle pulse, result/flags valid from this cycle on
//   ovf    out  1           decimal value >= 2^WIDTH (bin holds low WIDTH bits)
//   err    out  1           some input digit > 9; conversion aborted
// BEHAVIOUR
//   Reset (async, reset=0): state=IDLE, bin=0, busy=0, done=0, ovf=0, err=0, counter=0, shift reg=0.
//   States: IDLE, SHIFT.
//   IDLE: start=1 at edge k ->
//     - any digit > 9: stay IDLE; after edge k: done=1, err=1, ovf=0, bin=0 (1-edge latency).
//     - else: load SR = {bcd, WIDTH'b0} (4*NDIGITS+WIDTH bits), counter=0, err=0, state=SHIFT, busy=1.
//   SHIFT: each edge performs one step: SR logical-shift-right by 1, then each BCD nibble of the shifted
//     upper field that is >= 8 has 3 subtracted (all nibbles in parallel, same step); counter+1.
//   Step WIDTH (edge k+WIDTH): bin = SR[WIDTH-1:0] after that step; ovf = (residual BCD field != 0);
//     busy=0, done=1 for the following cycle only, state=IDLE. Latency start-edge to done = WIDTH+1 edges.
//   done deasserts next edge unless another conversion completes there.
//   start while busy=1: ignored, no queueing; bcd changes during SHIFT have no effect.
//   start in the cycle done=1: accepted (state is IDLE); done still drops, busy rises after that edge.
//   start held continuously: back-to-back conversions, one every WIDTH+1 edges.
//   Reset mid-conversion: immediate return to reset values; no done pulse for the aborted conversion.
//   Max input at defaults 99999 -> ovf=1, bin=99999-65536=34463.
//   No combinational path from inputs to outputs; all outputs registered.
// TESTING
//   1 bcd=20'h00000, start 1 cycle -> done after 17 edges, bin=16'h0000, ovf=0, err=0; busy high 16 cycles.
//   2 bcd=20'h12345 -> bin=16'h3039, ovf=0; bcd=20'h65535 -> bin=16'hFFFF, ovf=0.
//   3 bcd=20'h65536 -> bin=16'h0000, ovf=1; bcd=20'h99999 -> bin=16'h869F, ovf=1.
//   4 bcd=20'h0A001 -> done 1 edge after start, err=1, bin=0, busy never rises; next valid start clears err.
//   5 start pulsed again at cycles 3 and 9 of a 12345 conversion -> ignored, single done, bin=16'h3039;
//     start asserted on done cycle with bcd=20'h00042 -> second done 17 edges later, bin=16'h002A.
//   6 reset low at cycle 8 of conversion -> all outputs 0 asynchronously, no done; fresh start then converts.
//   Plus random sweep 0..99999 vs reference model (value mod 65536, value>65535).

Source files
------------

// File: rtl/bcd_to_bin_seq.sv
// Sequential packed-BCD to binary converter (reverse double-dabble).
// One shift step per clock; start/busy/done handshake with overflow and bad-digit flags.
module bcd_to_bin_seq #(
  parameter int NDIGITS = 5,
  parameter int WIDTH   = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [4*NDIGITS-1:0]   bcd,
  output logic [WIDTH-1:0]       bin,
  output logic                   busy,
  output logic                   done,
  output logic                   ovf,
  output logic                   err
);

  localparam int CNTW = $clog2(WIDTH + 1);
  localparam int BCDW = 4 * NDIGITS;
  localparam int SRW  = BCDW + WIDTH;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state_q;
  logic [SRW-1:0]   sr_q, sr_d;
  logic [CNTW-1:0]  cnt_q;
  logic [WIDTH-1:0] bin_q;
  logic             busy_q, done_q, ovf_q, err_q;
  logic             bad_digit;
  logic             last_step;

  always_comb begin
    bad_digit = 1'b0;
    for (int unsigned i = 0; i < NDIGITS; i++) begin
      if (bcd[4*i +: 4] > 4'd9) bad_digit = 1'b1;
    end
  end

  // Shift right, then pull each BCD nibble that received a carried-in 8 back into 0..9 range.
  always_comb begin
    sr_d = sr_q >> 1;
    for (int unsigned i = 0; i < NDIGITS; i++) begin
      if (sr_d[WIDTH + 4*i +: 4] >= 4'd8)
        sr_d[WIDTH + 4*i +: 4] = sr_d[WIDTH + 4*i +: 4] - 4'd3;
    end
  end

  assign last_step = (cnt_q == CNTW'(WIDTH - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      bin_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            if (bad_digit) begin
              done_q <= 1'b1;
              err_q  <= 1'b1;
              ovf_q  <= 1'b0;
              bin_q  <= '0;
            end else begin
              sr_q    <= {bcd, {WIDTH{1'b0}}};
              cnt_q   <= '0;
              err_q   <= 1'b0;
              busy_q  <= 1'b1;
              state_q <= SHIFT;
            end
          end
        end
        SHIFT: begin
          sr_q  <= sr_d;
          cnt_q <= cnt_q + CNTW'(1);
          if (last_step) begin
            bin_q   <= sr_d[WIDTH-1:0];
            ovf_q   <= |sr_d[SRW-1:WIDTH];
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bin  = bin_q;
  assign busy = busy_q;
  assign done = done_q;
  assign ovf  = ovf_q;
  assign err  = err_q;

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Directed and randomized bench for bcd_to_bin_seq; expected results come from decimal arithmetic.
module tb_bcd_to_bin_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [19:0] bcd;
  logic [15:0] bin;
  logic        busy, done, ovf, err;

  int vectors = 0;
  int miscompares = 0;

  bcd_to_bin_seq #(.NDIGITS(5), .WIDTH(16)) dut (
    .clk(clk), .reset(reset), .start(start), .bcd(bcd),
    .bin(bin), .busy(busy), .done(done), .ovf(ovf), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Decimal value of a packed-BCD word, plus whether any digit is out of range.
  task automatic ref_model(input logic [19:0] b, output int unsigned val, output logic bad);
    logic [19:0] t;
    int unsigned scale;
    t = b; val = 0; bad = 1'b0; scale = 1;
    for (int i = 0; i < 5; i++) begin
      if (t[3:0] > 4'd9) bad = 1'b1;
      val += 32'(t[3:0]) * scale;
      scale *= 10;
      t = t >> 4;
    end
  endtask

  function automatic logic [19:0] to_bcd(input int unsigned v);
    logic [19:0] r;
    int unsigned x;
    r = '0; x = v;
    for (int i = 0; i < 5; i++) begin
      r = r | (20'(x % 10) << (4 * i));
      x = x / 10;
    end
    return r;
  endfunction

  // Pulse start for one edge, then follow the conversion until done (bounded).
  task automatic convert(input logic [19:0] b, output int edges, output int busy_cyc);
    @(negedge clk);
    bcd = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; edges = 1; busy_cyc = 0;
    while (!done && edges < 40) begin
      if (busy) busy_cyc++;
      @(posedge clk); #1;
      edges++;
    end
  endtask

  task automatic check_conv(input string tag, input logic [19:0] b);
    int unsigned val;
    logic bad;
    int edges, bc;
    ref_model(b, val, bad);
    convert(b, edges, bc);
    chk({tag, ".done"}, 32'(done), 32'd1);
    chk({tag, ".lat"}, edges, bad ? 32'd1 : 32'd17);
    chk({tag, ".busy_cycles"}, bc, bad ? 32'd0 : 32'd16);
    chk({tag, ".err"}, 32'(err), 32'(bad));
    chk({tag, ".bin"}, 32'(bin), bad ? 32'd0 : (val % 65536));
    chk({tag, ".ovf"}, 32'(ovf), bad ? 32'd0 : 32'(val > 65535));
  endtask

  initial begin
    int edges, bc, ndone;
    logic [19:0] r;
    reset = 1'b0; start = 1'b0; bcd = '0;
    #12;
    chk("reset.bin", 32'(bin), 32'd0);
    chk("reset.busy", 32'(busy), 32'd0);
    chk("reset.done", 32'(done), 32'd0);
    chk("reset.ovf", 32'(ovf), 32'd0);
    chk("reset.err", 32'(err), 32'd0);
    @(negedge clk); reset = 1'b1;

    check_conv("zero", 20'h00000);
    @(posedge clk); #1;
    chk("zero.done_drop", 32'(done), 32'd0);
    check_conv("d12345", 20'h12345);
    check_conv("d65535", 20'h65535);
    check_conv("d65536", 20'h65536);
    check_conv("d99999", 20'h99999);
    check_conv("bad", 20'h0A001);
    check_conv("after_bad", 20'h00007);

    // start pulses during a conversion are ignored; start on the done cycle is accepted
    @(negedge clk); bcd = 20'h12345; start = 1'b1;
    @(posedge clk); #1; start = 1'b0; edges = 1; ndone = 0;
    while (!done && edges < 40) begin
      start = (edges == 3 || edges == 9);
      bcd = start ? 20'h99999 : 20'h12345;
      @(posedge clk); #1;
      edges++;
    end
    chk("ignore.lat", edges, 32'd17);
    chk("ignore.bin", 32'(bin), 32'h3039);
    bcd = 20'h00042; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    chk("b2b.done_drop", 32'(done), 32'd0);
    chk("b2b.busy", 32'(busy), 32'd1);
    edges = 1;
    while (!done && edges < 40) begin
      if (done) ndone++;
      @(posedge clk); #1;
      edges++;
    end
    chk("b2b.lat", edges, 32'd17);
    chk("b2b.bin", 32'(bin), 32'h002A);

    // asynchronous reset mid-conversion
    @(negedge clk); bcd = 20'h54321; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (7) @(posedge clk);
    #3; reset = 1'b0; #1;
    chk("areset.busy", 32'(busy), 32'd0);
    chk("areset.bin", 32'(bin), 32'd0);
    chk("areset.err", 32'(err), 32'd0);
    ndone = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    @(negedge clk); reset = 1'b1;
    repeat (12) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    chk("areset.no_done", ndone, 32'd0);
    check_conv("fresh", 20'h00123);

    // random sweep over valid decimals, then over raw nibble patterns
    repeat (40) check_conv("rand", to_bcd($urandom_range(0, 99999)));
    repeat (10) begin
      r = 20'($urandom);
      check_conv("raw", r);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
